// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/result bundle between the execute stage and alu_muldiv
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [4:0]       i_alu_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             o_valid;
    logic [WIDTH-1:0] o_alu_data;

    modport master (
        output i_valid, i_alu_op, i_operand_a, i_operand_b,
        input  o_ready, o_valid, o_alu_data
    );

    modport slave (
        input  i_valid, i_alu_op, i_operand_a, i_operand_b,
        output o_ready, o_valid, o_alu_data
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle integer ALU plus iterative RV32M multiply/divide unit
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    alu_muldiv_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state;
    logic [SHW-1:0]     count;
    logic [2:0]         mop;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       op;
    logic [SHW-1:0]   shamt;
    logic             accept;

    assign a      = bus.i_operand_a;
    assign b      = bus.i_operand_b;
    assign op     = bus.i_alu_op;
    assign shamt  = b[SHW-1:0];
    assign bus.o_ready = (state == IDLE) && !i_reset;
    assign accept = bus.i_valid && bus.o_ready;

    logic [WIDTH-1:0] base_res;

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = a + b;
            4'b1000: base_res = a - b;
            4'b0001: base_res = a << shamt;
            4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: base_res = {{(WIDTH-1){1'b0}}, a < b};
            4'b0100: base_res = a ^ b;
            4'b0101: base_res = a >> shamt;
            4'b1101: base_res = $unsigned($signed(a) >>> shamt);
            4'b0110: base_res = a | b;
            4'b0111: base_res = a & b;
            4'b1111: base_res = b;
            default: base_res = '0;
        endcase
    end

    // Operand signedness per M op: MULH/DIV/REM sign both, MULHSU signs only A.
    logic             sign_a_in;
    logic             sign_b_in;
    logic             neg_a_in;
    logic             neg_b_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    always_comb begin
        sign_a_in = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                    (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        sign_b_in = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        neg_a_in  = sign_a_in && a[WIDTH-1];
        neg_b_in  = sign_b_in && b[WIDTH-1];
        mag_a_in  = neg_a_in ? -a : a;
        mag_b_in  = neg_b_in ? -b : b;
    end

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;

    // Multiply: multiplier sits in prod's low half and shifts out as the product shifts in.
    // Divide: prod's low half shifts dividend bits out and quotient bits in.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, addend} : '0);
    assign div_shift = {rem, prod[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, addend};

    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               b_zero;
    logic               ovf;
    logic [WIDTH-1:0]   div_res;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        mul_full = (a_neg ^ b_neg) ? -prod : prod;
        mul_res  = (mop[1:0] == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
        quo_s    = (a_neg ^ b_neg) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_s    = a_neg ? -rem : rem;
        b_zero   = (addend == '0);
        ovf      = !mop[0] && (a_raw == MOST_NEG) && b_neg && (addend == {{(WIDTH-1){1'b0}}, 1'b1});
        if (mop[1])
            div_res = b_zero ? a_raw : (ovf ? '0 : rem_s);
        else
            div_res = b_zero ? '1 : (ovf ? a_raw : quo_s);
        fin_res  = mop[2] ? div_res : mul_res;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            count          <= '0;
            mop            <= '0;
            a_neg          <= 1'b0;
            b_neg          <= 1'b0;
            a_raw          <= '0;
            addend         <= '0;
            prod           <= '0;
            rem            <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_alu_data <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op[4]) begin
                            bus.o_alu_data <= base_res;
                            bus.o_valid    <= 1'b1;
                        end else begin
                            mop   <= op[2:0];
                            a_neg <= neg_a_in;
                            b_neg <= neg_b_in;
                            a_raw <= a;
                            count <= '0;
                            rem   <= '0;
                            state <= CALC;
                            if (op[2]) begin
                                addend <= mag_b_in;
                                prod   <= {{WIDTH{1'b0}}, mag_a_in};
                            end else begin
                                addend <= mag_a_in;
                                prod   <= {{WIDTH{1'b0}}, mag_b_in};
                            end
                        end
                    end
                end
                CALC: begin
                    if (mop[2]) begin
                        if (!div_trial[WIDTH]) begin
                            rem              <= div_trial[WIDTH-1:0];
                            prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b1};
                        end else begin
                            rem              <= div_shift[WIDTH-1:0];
                            prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == SHW'(WIDTH-1))
                        state <= FIN;
                end
                FIN: begin
                    bus.o_alu_data <= fin_res;
                    bus.o_valid    <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
